sd_loader: RTL and testbench

Serial-to-parallel front end for the sort-and-divide stage. Accepts a stream of 4-bit operands one per cycle and assembles them into 4-operand frames. Each finished frame is presented as four stable nibbles plus a mode bit, using a valid/ready handshake. The block double-buffers: it can collect the next frame while the current one waits on the consumer. It sits directly upstream of the combinational sort/divide datapath and drives that datapath's `in_n0..in_n3` and `mode` inputs.

---
 rtl/sd_loader_if.sv | 33 +++
 rtl/sd_loader.sv | 122 ++++++++++++
 tb/tb_sd_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sd_loader_if.sv
// Handshake bundle between the operand stream source, sd_loader and the
// downstream sort/divide datapath.
interface sd_loader_if #(
    parameter int WIDTH  = 4,
    parameter int FCNT_W = 8
);
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_mode;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_n0;
    logic [WIDTH-1:0]  out_n1;
    logic [WIDTH-1:0]  out_n2;
    logic [WIDTH-1:0]  out_n3;
    logic              out_mode;
    logic              frame_err;
    logic [FCNT_W-1:0] frame_cnt;

    // master: the side that feeds operands and consumes frames
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_n0, out_n1, out_n2, out_n3,
               out_mode, frame_err, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_n0, out_n1, out_n2, out_n3,
               out_mode, frame_err, frame_cnt
    );
endinterface

// File: rtl/sd_loader.sv
// Serial-to-parallel operand loader: assembles 4-beat frames into a
// double-buffered (collector + output register) valid/ready stage.
module sd_loader #(
    parameter int WIDTH  = 4,
    parameter int FCNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    sd_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              cnt, cnt_nxt;
    logic [3:0][WIDTH-1:0]   col_n, col_n_nxt;
    logic                    col_mode, col_mode_nxt;
    logic [3:0][WIDTH-1:0]   out_n;
    logic                    out_mode;
    logic                    out_valid;
    logic                    frame_err, err_nxt;
    logic [FCNT_W-1:0]       frame_cnt;
    logic                    load_out;
    logic                    handoff;
    logic                    out_free;

    assign handoff  = out_valid && bus.out_ready;
    assign out_free = !out_valid || bus.out_ready;

    // Collector next-state; col_n_nxt already holds the incoming beat so a
    // frame completing this cycle can go straight to the output register.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        col_n_nxt    = col_n;
        col_mode_nxt = col_mode;
        err_nxt      = 1'b0;
        load_out     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    col_n_nxt[0] = bus.in_data;
                    col_mode_nxt = bus.in_mode;
                    cnt_nxt      = 2'd1;
                    state_nxt    = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    col_n_nxt[cnt] = bus.in_data;
                    if (cnt == 2'd3) begin
                        cnt_nxt = 2'd0;
                        if (out_free) begin
                            load_out  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = FULL;
                        end
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end else begin
                    cnt_nxt   = 2'd0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FULL: begin
                if (handoff) begin
                    load_out  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            col_n     <= '0;
            col_mode  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            col_n     <= col_n_nxt;
            col_mode  <= col_mode_nxt;
            frame_err <= err_nxt;
        end
    end

    // Load wins over handoff so back-to-back frames keep out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_n     <= '0;
            out_mode  <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (load_out) begin
                out_n     <= col_n_nxt;
                out_mode  <= col_mode_nxt;
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (handoff)
                frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = out_valid;
    assign bus.out_n0    = out_n[0];
    assign bus.out_n1    = out_n[1];
    assign bus.out_n2    = out_n[2];
    assign bus.out_n3    = out_n[3];
    assign bus.out_mode  = out_mode;
    assign bus.frame_err = frame_err;
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_sd_loader.sv
// Directed bench for sd_loader: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed per scenario.
module tb_sd_loader;
    localparam int W  = 4;
    localparam int FW = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    sd_loader_if #(.WIDTH(W), .FCNT_W(FW)) bus ();

    sd_loader #(.WIDTH(W), .FCNT_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4*W-1:0] frame = {bus.out_n0, bus.out_n1, bus.out_n2, bus.out_n3};

    task automatic send_beat(input logic [W-1:0] d, input logic m);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mode  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests++; if (frame !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", frame); end
        tests++; if ({bus.out_mode, bus.frame_err} !== 2'b00) begin fails++; $display("FAIL reset_mode_err: got %b want 00", {bus.out_mode, bus.frame_err}); end
        tests++; if (bus.frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", bus.frame_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        bus.out_ready = 1'b1;
        send_beat(4'd9, 1'b0); send_beat(4'd3, 1'b0);
        send_beat(4'd7, 1'b0); send_beat(4'd1, 1'b0);
        idle_cycle();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        tests++; if (frame !== 16'h9371) begin fails++; $display("FAIL single_data: got %h want 9371", frame); end
        tests++; if (bus.out_mode !== 1'b0) begin fails++; $display("FAIL single_mode: got %b want 0", bus.out_mode); end
        idle_cycle();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %b want 0", bus.out_valid); end
        tests++; if (bus.frame_cnt !== 8'd1) begin fails++; $display("FAIL single_cnt: got %0d want 1", bus.frame_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send_beat(4'd1, 1'b0); send_beat(4'd2, 1'b0);
        send_beat(4'd3, 1'b0); send_beat(4'd4, 1'b0);
        send_beat(4'd15, 1'b1); send_beat(4'd14, 1'b0);
        send_beat(4'd13, 1'b0); send_beat(4'd12, 1'b0);
        idle_cycle();
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        tests++; if (frame !== 16'h1234) begin fails++; $display("FAIL bp_hold_a: got %h want 1234", frame); end
        idle_cycle();
        tests++; if ({bus.out_valid, bus.in_ready, bus.frame_err} !== 3'b100) begin fails++; $display("FAIL bp_stall: got %b want 100", {bus.out_valid, bus.in_ready, bus.frame_err}); end
        tests++; if (frame !== 16'h1234) begin fails++; $display("FAIL bp_stable_a: got %h want 1234", frame); end
        bus.out_ready = 1'b1;
        idle_cycle();
        tests++; if ({bus.out_valid, bus.in_ready} !== 2'b11) begin fails++; $display("FAIL b2b_flags: got %b want 11", {bus.out_valid, bus.in_ready}); end
        tests++; if ({frame, bus.out_mode} !== {16'hFEDC, 1'b1}) begin fails++; $display("FAIL b2b_data_b: got %h/%b want fedc/1", frame, bus.out_mode); end
        tests++; if (bus.frame_cnt !== 8'd2) begin fails++; $display("FAIL b2b_cnt_a: got %0d want 2", bus.frame_cnt); end
        idle_cycle();
        tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL b2b_drain: got %b want 01", {bus.out_valid, bus.in_ready}); end
        tests++; if (bus.frame_cnt !== 8'd3) begin fails++; $display("FAIL b2b_cnt_b: got %0d want 3", bus.frame_cnt); end
    endtask

    task automatic test_gap_abort();
        send_beat(4'd5, 1'b0); send_beat(4'd6, 1'b0);
        idle_cycle();
        idle_cycle();
        tests++; if ({bus.frame_err, bus.out_valid} !== 2'b10) begin fails++; $display("FAIL gap_pulse: got %b want 10", {bus.frame_err, bus.out_valid}); end
        idle_cycle();
        tests++; if ({bus.frame_err, bus.out_valid} !== 2'b00) begin fails++; $display("FAIL gap_one_cycle: got %b want 00", {bus.frame_err, bus.out_valid}); end
        send_beat(4'd8, 1'b0); send_beat(4'd0, 1'b0);
        send_beat(4'd2, 1'b0); send_beat(4'd4, 1'b0);
        idle_cycle();
        tests++; if ({bus.out_valid, frame} !== {1'b1, 16'h8024}) begin fails++; $display("FAIL gap_recover: got %b/%h want 1/8024", bus.out_valid, frame); end
        idle_cycle();
        idle_cycle();
        tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL gap_idle_err: got %b want 0", bus.frame_err); end
        tests++; if (bus.frame_cnt !== 8'd4) begin fails++; $display("FAIL gap_cnt: got %0d want 4", bus.frame_cnt); end
    endtask

    task automatic test_mode();
        send_beat(4'd1, 1'b1); send_beat(4'd2, 1'b0);
        send_beat(4'd3, 1'b0); send_beat(4'd4, 1'b0);
        idle_cycle();
        tests++; if (bus.out_mode !== 1'b1) begin fails++; $display("FAIL mode_first_1: got %b want 1", bus.out_mode); end
        idle_cycle();
        bus.out_ready = 1'b0;
        send_beat(4'd5, 1'b0); send_beat(4'd6, 1'b1);
        send_beat(4'd7, 1'b1); send_beat(4'd8, 1'b1);
        idle_cycle();
        tests++; if ({bus.out_valid, bus.out_mode, frame} !== {2'b10, 16'h5678}) begin fails++; $display("FAIL mode_first_0: got %b/%b/%h want 1/0/5678", bus.out_valid, bus.out_mode, frame); end
        tests++; if (bus.frame_cnt !== 8'd5) begin fails++; $display("FAIL mode_cnt: got %0d want 5", bus.frame_cnt); end
    endtask

    task automatic test_reset_mid();
        send_beat(4'd7, 1'b1); send_beat(4'd7, 1'b0); send_beat(4'd7, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if ({bus.out_valid, bus.in_ready, bus.out_mode, bus.frame_err} !== 4'b0100) begin fails++; $display("FAIL rstmid_flags: got %b want 0100", {bus.out_valid, bus.in_ready, bus.out_mode, bus.frame_err}); end
        tests++; if (frame !== 16'h0000) begin fails++; $display("FAIL rstmid_data: got %h want 0000", frame); end
        tests++; if (bus.frame_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d want 0", bus.frame_cnt); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send_beat(4'd10, 1'b0); send_beat(4'd11, 1'b0);
        send_beat(4'd12, 1'b0); send_beat(4'd13, 1'b0);
        idle_cycle();
        tests++; if ({bus.out_valid, frame, bus.frame_err} !== {1'b1, 16'hABCD, 1'b0}) begin fails++; $display("FAIL rstmid_fresh: got %b/%h/%b want 1/abcd/0", bus.out_valid, frame, bus.frame_err); end
        idle_cycle();
        tests++; if (bus.frame_cnt !== 8'd1) begin fails++; $display("FAIL rstmid_cnt_after: got %0d want 1", bus.frame_cnt); end
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int f = 0; f < 255; f++)
            for (int b = 0; b < 4; b++)
                send_beat(4'(f + b), 1'b0);
        idle_cycle();
        idle_cycle();
        tests++; if (bus.frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", bus.frame_cnt); end
        send_beat(4'd3, 1'b0); send_beat(4'd1, 1'b0);
        send_beat(4'd4, 1'b0); send_beat(4'd1, 1'b0);
        idle_cycle();
        tests++; if (frame !== 16'h3141) begin fails++; $display("FAIL wrap_last_data: got %h want 3141", frame); end
        idle_cycle();
        tests++; if (bus.frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_zero: got %0d want 0", bus.frame_cnt); end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap_abort();
        test_mode();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
